// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
//   Fills a ROWS x COLS operand matrix from a DW-bit valid/ready element stream
//   and presents the whole matrix flattened to the compute array. Elements are
//   placed row-major, or column-major when transpose is latched at start. A load
//   can be cancelled with abort. Sits between the operand bus and the matrix
//   multiplier as the operand-A/B loader.
//
// Ports
//   clk_i          clock, all state on rising edge
//   reset_i        asynchronous active-high reset
//   start_i        begin a new load (sampled in IDLE only)
//   transpose_i    placement mode, latched on accepted start
//   abort_i        cancel the load in progress
//   in_valid_i     in_data_i carries an element
//   in_data_i      element data
//   in_ready_o     loader accepts an element this cycle
//   busy_o         load in progress
//   done_o         one-cycle pulse: matrix complete
//   matrix_valid_o data_out_o holds a complete matrix
//   elem_count_o   elements accepted in the current load
//   data_out_o     element (r,c) at bits [(r*COLS+c)*DW +: DW]
// -----------------------------------------------------------------------------

// Single storage element: one DW-bit register with write enable.
module matrix_stream_loader_cell #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module matrix_stream_loader #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic                            transpose_i,
  input  logic                            abort_i,
  input  logic                            in_valid_i,
  input  logic [DW-1:0]                   in_data_i,
  output logic                            in_ready_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            matrix_valid_o,
  output logic [$clog2(ROWS*COLS+1)-1:0]  elem_count_o,
  output logic [ROWS*COLS*DW-1:0]         data_out_o
);
  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  // One accepted beat headed for the storage array.
  typedef struct packed {
    logic          en;
    logic [RW-1:0] row;
    logic [KW-1:0] col;
    logic [DW-1:0] data;
  } wr_req_t;

  state_t        state_q;
  logic          tr_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] r_q, r_d;
  logic [KW-1:0] c_q, c_d;
  logic          in_ready_q, busy_q, done_q, mvalid_q;
  logic          last;
  wr_req_t       wr;

  // abort beats a same-cycle beat: nothing is written on an abort cycle.
  assign wr.en   = (state_q == S_LOAD) && in_valid_i && in_ready_q && !abort_i;
  assign wr.row  = r_q;
  assign wr.col  = c_q;
  assign wr.data = in_data_i;

  assign last = (cnt_q == CW'(N - 1));

  // Next placement position. Row/col counters replace k/COLS, k%COLS (or the
  // ROWS pair when transposed) so no divider is needed.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (!tr_q) begin
      if (c_q == KW'(COLS - 1)) begin
        c_d = '0;
        r_d = r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end else begin
      if (r_q == RW'(ROWS - 1)) begin
        r_d = '0;
        c_d = c_q + 1'b1;
      end else begin
        r_d = r_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      tr_q       <= 1'b0;
      cnt_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mvalid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= S_LOAD;
            tr_q       <= transpose_i;
            cnt_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            mvalid_q   <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (wr.en) begin
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              // Park the position; it is reloaded on the next start anyway.
              r_q        <= '0;
              c_q        <= '0;
            end else begin
              r_q <= r_d;
              c_q <= c_d;
            end
          end
        end
        S_DONE: begin
          // start here is deliberately dropped; it must come again in IDLE.
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          mvalid_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage array, one cell per element, decoded from the write position.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic we;
      assign we = wr.en && (wr.row == RW'(gr)) && (wr.col == KW'(gc));
      matrix_stream_loader_cell #(.DW(DW)) u_cell (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (we),
        .d_i     (wr.data),
        .q_o     (data_out_o[(gr*COLS+gc)*DW +: DW])
      );
    end
  end

  assign in_ready_o     = in_ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign matrix_valid_o = mvalid_q;
  assign elem_count_o   = cnt_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: a 4x4x32 instance driven from a vector
// table plus randomized streams checked against an array model of the matrix,
// and a 2x3x8 instance for non-square transposed placement.
module tb_matrix_stream_loader;
  localparam int R = 4, C = 4, W = 32, N = R * C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 0, tr = 0, abort = 0, iv = 0;
  logic [W-1:0]  id = '0;
  logic          rdy, busy, done, mv;
  logic [4:0]    cnt;
  logic [N*W-1:0] dout;

  logic          s2_start = 0, s2_tr = 0, s2_abort = 0, s2_iv = 0;
  logic [7:0]    s2_id = '0;
  logic          rdy2, busy2, done2, mv2;
  logic [2:0]    cnt2;
  logic [47:0]   dout2;

  matrix_stream_loader #(.ROWS(R), .COLS(C), .DW(W)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .transpose_i(tr),
    .abort_i(abort), .in_valid_i(iv), .in_data_i(id), .in_ready_o(rdy),
    .busy_o(busy), .done_o(done), .matrix_valid_o(mv), .elem_count_o(cnt),
    .data_out_o(dout)
  );

  matrix_stream_loader #(.ROWS(2), .COLS(3), .DW(8)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(s2_start), .transpose_i(s2_tr),
    .abort_i(s2_abort), .in_valid_i(s2_iv), .in_data_i(s2_id), .in_ready_o(rdy2),
    .busy_o(busy2), .done_o(done2), .matrix_valid_o(mv2), .elem_count_o(cnt2),
    .data_out_o(dout2)
  );

  int ncmp = 0, nerr = 0;
  logic [W-1:0] model [N];
  logic [W-1:0] dat [N];

  typedef struct {
    bit t;        // transpose
    int vm;       // 0 all valid, 1 toggle, 2 random
    int ak;       // beat index carrying abort, -1 none
    bit seq;      // data k+1 (else random)
    bit sdone;    // pulse start during DONE
    int exp_lc;   // expected LOAD cycles, -1 don't care
    bit exp_done;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Placement rule straight from the index arithmetic: linear storage slot.
  function automatic int slot(input int k, input bit t);
    return t ? (k % R) * C + k / R : k;
  endfunction

  task automatic chk_mat(input string nm);
    int bad = -1;
    ncmp++;
    for (int i = 0; i < N; i++)
      if (bad < 0 && dout[i*W +: W] !== model[i]) bad = i;
    if (bad >= 0) begin
      nerr++;
      $display("FAIL %s: elem %0d got %0h expected %0h", nm, bad, dout[bad*W +: W], model[bad]);
    end
  endtask

  task automatic do_load(input vec_t v, output int lc, output bit got_done);
    int k = 0, cyc = 0;
    bit aborted = 0, b;
    for (int i = 0; i < N; i++) dat[i] = v.seq ? W'(i + 1) : $urandom;
    start = 1; tr = v.t;
    step();
    start = 0; tr = 1'($urandom_range(0, 1));
    chk("start_busy", busy, 1); chk("start_ready", rdy, 1);
    chk("start_cnt", cnt, 0);   chk("start_mv", mv, 0);
    while (k < N && cyc < 200 && !aborted) begin
      case (v.vm)
        0: b = 1;
        1: b = (cyc % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      iv = b; id = b ? dat[k] : $urandom;
      abort = b && (k == v.ak);
      start = 1'($urandom_range(0, 1));
      step(); cyc++;
      if (abort) begin
        aborted = 1; abort = 0; iv = 0; start = 0;
        chk("abort_busy", busy, 0); chk("abort_ready", rdy, 0);
        chk("abort_done", done, 0); chk("abort_cnt", cnt, 0);
        chk("abort_mv", mv, 0);
      end else begin
        if (b) begin model[slot(k, v.t)] = dat[k]; k++; end
        chk("beat_cnt", cnt, 64'(k));
        if (k < N) chk("beat_ready", rdy, 1);
      end
    end
    start = 0; abort = 0; iv = 0;
    lc = cyc; got_done = 0;
    if (!aborted) begin
      if (k < N) begin
        ncmp++; nerr++;
        $display("FAIL load_timeout: got %0d beats expected %0d", k, N);
      end
      chk("done_pulse", done, 1); chk("done_ready", rdy, 0);
      chk("done_busy", busy, 0);  chk("done_cnt", cnt, 16);
      chk("done_mv_early", mv, 0);
      got_done = done;
      start = v.sdone; iv = 1; id = $urandom; abort = 1'($urandom_range(0, 1));
      step();
      start = 0; iv = 0; abort = 0;
      chk("post_done", done, 0); chk("post_busy", busy, 0);
      chk("post_mv", mv, 1);     chk("post_cnt", cnt, 16);
    end else begin
      iv = 1; id = $urandom;
      step();
      iv = 0;
      chk("idle_done", done, 0); chk("idle_busy", busy, 0);
    end
    chk_mat("matrix");
  endtask

  vec_t vt [7];

  initial begin
    int lc;
    bit gd;
    vt[0] = '{0, 0, -1, 1, 0, 16, 1};
    vt[1] = '{1, 0, -1, 1, 0, 16, 1};
    vt[2] = '{0, 1, -1, 1, 1, 31, 1};
    vt[3] = '{0, 0,  6, 0, 0, -1, 0};
    vt[4] = '{1, 2, -1, 0, 1, -1, 1};
    vt[5] = '{1, 2, 10, 0, 0, -1, 0};
    vt[6] = '{0, 2, -1, 0, 0, -1, 1};
    for (int i = 0; i < N; i++) model[i] = '0;

    step(); step();
    chk("rst_ready", rdy, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_mv", mv, 0);     chk("rst_cnt", cnt, 0);
    chk_mat("rst_matrix");
    reset = 0;

    // Stray valid/abort in IDLE must not touch anything.
    iv = 1; abort = 1;
    for (int i = 0; i < 3; i++) begin id = $urandom; step(); end
    iv = 0; abort = 0;
    chk("idle_ign_busy", busy, 0); chk("idle_ign_cnt", cnt, 0);
    chk_mat("idle_ign_matrix");

    for (int i = 0; i < 7; i++) begin
      do_load(vt[i], lc, gd);
      if (vt[i].exp_lc >= 0) chk("load_cycles", 64'(lc), 64'(vt[i].exp_lc));
      chk("got_done", gd, vt[i].exp_done);
      if (vt[i].seq && vt[i].ak < 0) begin
        int bad = -1;
        ncmp++;
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            if (bad < 0 && dout[(r*C+c)*W +: W] !== W'(vt[i].t ? c*4+r+1 : r*4+c+1))
              bad = r*C + c;
        if (bad >= 0) begin
          nerr++;
          $display("FAIL layout: elem %0d got %0h expected %0h", bad, dout[bad*W +: W],
                   vt[i].t ? (bad%C)*4 + bad/C + 1 : bad + 1);
        end
      end
    end

    // 2x3 transposed load of 0..5.
    s2_start = 1; s2_tr = 1;
    step();
    s2_start = 0; s2_tr = 0;
    for (int k = 0; k < 6; k++) begin s2_iv = 1; s2_id = 8'(k); step(); end
    s2_iv = 0;
    chk("s2_done", done2, 1); chk("s2_cnt", cnt2, 6);
    step();
    chk("s2_mv", mv2, 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("s2_elem_%0d_%0d", r, c), dout2[(r*3+c)*8 +: 8], 64'(c*2 + r));

    // Reset in the middle of a load, away from any clock edge.
    start = 1; tr = 0;
    step();
    start = 0;
    for (int k = 0; k < 5; k++) begin
      iv = 1; id = $urandom; model[k] = id; step();
    end
    iv = 0;
    chk_mat("pre_reset_matrix");
    #2 reset = 1;
    #1;
    for (int i = 0; i < N; i++) model[i] = '0;
    chk("mrst_ready", rdy, 0); chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    chk("mrst_mv", mv, 0);     chk("mrst_cnt", cnt, 0);
    chk_mat("mrst_matrix");
    chk("mrst_s2_mv", mv2, 0); chk("mrst_s2_data", dout2, 0);
    step();
    reset = 0;
    step();
    chk("mrst_idle", busy, 0);
    do_load(vt[6], lc, gd);
    chk("recover_done", gd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
